// File: rtl/tx_burst_ramp.sv
// TX burst gain ramp between the baseband stream and the DUC: ramp up, hold, tail ramp down, mute.
// Define TX_BURST_RAMP_ROUND_EN for round-half-up scaling; otherwise the scaling truncates (floor).
module tx_burst_ramp #(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        run,
  input  logic        duc_in_strobe,
  output logic [31:0] duc_in_sample,
  output logic        bb_strobe,
  input  logic [31:0] bb_sample,
  output logic        burst_done
);

  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE} state_t;

  localparam logic [15:0] UNITY     = 16'h8000;
  localparam logic [7:0]  ADDR_STEP = 8'(BASE);
  localparam logic [7:0]  ADDR_LEN  = 8'(BASE + 1);
  localparam logic [7:0]  ADDR_TAIL = 8'(BASE + 2);

  state_t      r_state;
  logic [15:0] r_step;
  logic [31:0] r_len;
  logic [15:0] r_tail;
  logic [31:0] r_len_l;
  logic [31:0] r_s;
  logic [31:0] r_k;
  logic [15:0] r_gain;
  logic        r_run_d;
  logic        r_done;

  logic [31:0] w_start_s;
  logic [31:0] w_k_next;
  logic [16:0] w_up_sum;
  logic [15:0] w_up_gain;
  logic [15:0] w_dn_gain;
  logic        w_bounded;
  logic        w_active;

  function automatic logic [15:0] scale(input logic [15:0] x, input logic [15:0] g);
    logic signed [31:0] p;
    p = $signed({{16{x[15]}}, x}) * $signed({16'h0000, g});
`ifdef TX_BURST_RAMP_ROUND_EN
    p = p + 32'sh0000_4000;
`endif
    scale = p[30:15];
  endfunction

  assign w_start_s = ({16'h0000, r_tail} >= r_len) ? 32'd0 : r_len - {16'h0000, r_tail};
  assign w_k_next  = (&r_k) ? r_k : r_k + 32'd1;
  assign w_up_sum  = {1'b0, r_gain} + {1'b0, r_step};
  assign w_up_gain = (w_up_sum >= {1'b0, UNITY}) ? UNITY : w_up_sum[15:0];
  assign w_dn_gain = (r_gain > r_step) ? r_gain - r_step : 16'h0000;
  assign w_bounded = (r_len_l != 32'd0);
  assign w_active  = (r_state == RAMP_UP) || (r_state == HOLD) || (r_state == RAMP_DOWN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_step  <= 16'h0100;
      r_len   <= 32'd0;
      r_tail  <= 16'h0000;
      r_len_l <= 32'd0;
      r_s     <= 32'd0;
      r_k     <= 32'd0;
      r_gain  <= 16'h0000;
      r_run_d <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_run_d <= run;
      r_done  <= 1'b0;
      if (set_stb) begin
        if (set_addr == ADDR_STEP) r_step <= set_data[15:0];
        if (set_addr == ADDR_LEN)  r_len  <= set_data;
        if (set_addr == ADDR_TAIL) r_tail <= set_data[15:0];
      end
      if (!enable || !run) begin
        r_state <= IDLE;
        r_gain  <= 16'h0000;
        r_k     <= 32'd0;
      end else begin
        case (r_state)
          IDLE: begin
            // Burst starts on the registered rising edge of run; a strobe this cycle is not counted.
            if (!r_run_d) begin
              r_len_l <= r_len;
              r_s     <= w_start_s;
              r_k     <= 32'd0;
              if ((r_len != 32'd0) && (w_start_s == 32'd0)) begin
                r_gain  <= UNITY;
                r_state <= RAMP_DOWN;
              end else if (r_step == 16'h0000) begin
                r_gain  <= UNITY;
                r_state <= HOLD;
              end else begin
                r_gain  <= 16'h0000;
                r_state <= RAMP_UP;
              end
            end
          end
          DONE: ;
          default: begin
            if (duc_in_strobe) begin
              r_k <= w_k_next;
              if (w_bounded && (w_k_next >= r_len_l)) begin
                r_state <= DONE;
                r_gain  <= 16'h0000;
                r_done  <= 1'b1;
              end else if (w_bounded && (w_k_next > r_s)) begin
                r_state <= RAMP_DOWN;
                if (r_step != 16'h0000) r_gain <= w_dn_gain;
              end else begin
                // Ramp-up rule also produces the tail starting gain at k == S.
                r_gain <= (r_step == 16'h0000) ? UNITY : w_up_gain;
                if (w_bounded && (w_k_next == r_s))
                  r_state <= RAMP_DOWN;
                else if ((r_step == 16'h0000) || (w_up_gain == UNITY))
                  r_state <= HOLD;
                else
                  r_state <= RAMP_UP;
              end
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    if (!enable)
      duc_in_sample = bb_sample;
    else if (w_active)
      duc_in_sample = {scale(bb_sample[31:16], r_gain), scale(bb_sample[15:0], r_gain)};
    else
      duc_in_sample = 32'h0000_0000;
  end

  assign bb_strobe  = duc_in_strobe;
  assign burst_done = r_done & enable;

endmodule
